// File: rtl/mig_mport_arbiter_if.sv
// Bundle of every non-clock signal between the cache-side requesters, the
// multi-port arbiter and the MIG user interface.
//   slave  : the arbiter's view (takes requests and MIG status, drives
//            grants, read returns and MIG commands/data)
//   master : the environment's view (requesters plus MIG model)
// Port p of the packed per-port buses occupies slice p; beat 0 of a line
// sits in the LSBs.
interface mig_mport_arbiter_if #(
  parameter int NUM_PORTS        = 2,
  parameter int APPDATA_WIDTH    = 128,
  parameter int BEATS            = 2,
  parameter int INPUT_ADDR_WIDTH = 31
);
  localparam int LINE_W = BEATS * APPDATA_WIDTH;

  logic                                  phy_init_done;
  logic [NUM_PORTS-1:0]                  port_wren;
  logic [NUM_PORTS-1:0]                  port_rden;
  logic [NUM_PORTS*INPUT_ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS*LINE_W-1:0]           port_wr_data;
  logic [NUM_PORTS-1:0]                  port_gnt;
  logic [NUM_PORTS-1:0]                  port_rd_valid;
  logic [LINE_W-1:0]                     port_rd_data;
  logic                                  app_af_afull;
  logic                                  app_wdf_afull;
  logic                                  app_af_wren;
  logic [2:0]                            app_af_cmd;
  logic [INPUT_ADDR_WIDTH-1:0]           app_af_addr;
  logic                                  app_wdf_wren;
  logic [APPDATA_WIDTH-1:0]              app_wdf_data;
  logic [APPDATA_WIDTH/8-1:0]            app_wdf_mask_data;
  logic                                  rd_data_valid;
  logic [APPDATA_WIDTH-1:0]              rd_data_fifo_out;
  logic                                  rd_tags_full;
  logic                                  err_unexp_rd;

  modport slave (
    input  phy_init_done, port_wren, port_rden, port_addr, port_wr_data,
           app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    output port_gnt, port_rd_valid, port_rd_data, app_af_wren, app_af_cmd,
           app_af_addr, app_wdf_wren, app_wdf_data, app_wdf_mask_data,
           rd_tags_full, err_unexp_rd
  );

  modport master (
    output phy_init_done, port_wren, port_rden, port_addr, port_wr_data,
           app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    input  port_gnt, port_rd_valid, port_rd_data, app_af_wren, app_af_cmd,
           app_af_addr, app_wdf_wren, app_wdf_data, app_wdf_mask_data,
           rd_tags_full, err_unexp_rd
  );
endinterface

// File: rtl/mig_mport_arbiter.sv
// Multi-port front end for the MIG DDR2 user interface.
// Round-robin arbitrates NUM_PORTS requesters, issues one MIG command per
// grant, serialises write lines into BEATS beats and reassembles read beats
// into lines that return, in issue order, to the port that asked for them.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mig_mport_arbiter_if.slave (requests, grants, read returns,
//           MIG command/write-data/read-data signals, status flags)
module mig_mport_arbiter #(
  parameter int NUM_PORTS        = 2,
  parameter int PORT_BITS        = 1,
  parameter int APPDATA_WIDTH    = 128,
  parameter int BEATS            = 2,
  parameter int INPUT_ADDR_WIDTH = 31,
  parameter int RD_TAGS          = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mig_mport_arbiter_if.slave      bus
);
  localparam int LINE_W = BEATS * APPDATA_WIDTH;
  localparam int AW     = INPUT_ADDR_WIDTH;
  localparam int DW     = APPDATA_WIDTH;
  // Write beat index must be able to hold BEATS ("all beats sent").
  localparam int WB_W   = $clog2(BEATS + 1);
  localparam int RB_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TAG_AW = (RD_TAGS > 1) ? $clog2(RD_TAGS) : 1;
  localparam int CNT_W  = $clog2(RD_TAGS + 1);

  localparam logic [WB_W-1:0]      BEATS_DONE = WB_W'(BEATS);
  localparam logic [RB_W-1:0]      LAST_RBEAT = RB_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]     TAGS_MAX   = CNT_W'(RD_TAGS);
  localparam logic [TAG_AW-1:0]    TAG_LAST   = TAG_AW'(RD_TAGS - 1);
  localparam logic [PORT_BITS-1:0] PORT_LAST  = PORT_BITS'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WR_DATA = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PORT_BITS-1:0]   rr_q, rr_d;
  logic                   op_wr_q, op_wr_d;
  logic [PORT_BITS-1:0]   win_q, win_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic [WB_W-1:0]        beat_q, beat_d;
  logic [NUM_PORTS-1:0]   port_gnt_q, port_gnt_d;
  logic                   af_wren_q, af_wren_d;
  logic [2:0]             af_cmd_q, af_cmd_d;
  logic [AW-1:0]          af_addr_q, af_addr_d;
  logic                   wdf_wren_q, wdf_wren_d;
  logic [DW-1:0]          wdf_data_q, wdf_data_d;

  logic [PORT_BITS-1:0]   tag_mem_q [RD_TAGS];
  logic [TAG_AW-1:0]      tag_wptr_q, tag_wptr_d;
  logic [TAG_AW-1:0]      tag_rptr_q, tag_rptr_d;
  logic [CNT_W-1:0]       tag_cnt_q, tag_cnt_d;
  logic                   tags_full_q, tags_full_d;
  logic [RB_W-1:0]        rd_beat_q, rd_beat_d;
  logic [LINE_W-1:0]      rd_line_q, rd_line_d;
  logic [NUM_PORTS-1:0]   rd_valid_q, rd_valid_d;
  logic [LINE_W-1:0]      rd_data_q, rd_data_d;
  logic                   err_q, err_d;

  logic                   wr_ok_s, rd_ok_s, found_s, wr_sel_s;
  logic                   send_try_s, push_s, pop_s;
  logic [PORT_BITS-1:0]   pick_s;
  int                     idx_s;

  // Arbitration, command issue and write-beat sequencing.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    op_wr_d    = op_wr_q;
    win_d      = win_q;
    line_d     = line_q;
    beat_d     = beat_q;
    port_gnt_d = {NUM_PORTS{1'b0}};
    af_wren_d  = 1'b0;
    af_cmd_d   = af_cmd_q;
    af_addr_d  = af_addr_q;
    wdf_wren_d = 1'b0;
    wdf_data_d = wdf_data_q;
    send_try_s = 1'b0;
    push_s     = 1'b0;
    found_s    = 1'b0;
    pick_s     = {PORT_BITS{1'b0}};
    idx_s      = 0;
    wr_ok_s    = bus.phy_init_done & ~bus.app_af_afull & ~bus.app_wdf_afull;
    rd_ok_s    = bus.phy_init_done & ~bus.app_af_afull & ~tags_full_q;

    // First qualified port at or after rr wins.
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx_s = (int'(rr_q) + i) % NUM_PORTS;
      if (!found_s && ((wr_ok_s && bus.port_wren[idx_s]) ||
                       (rd_ok_s && bus.port_rden[idx_s]))) begin
        found_s = 1'b1;
        pick_s  = PORT_BITS'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
    // A port holding both wren and rden gets its write first.
    wr_sel_s = wr_ok_s & bus.port_wren[pick_s];

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d    = S_ISSUE;
          win_d      = pick_s;
          op_wr_d    = wr_sel_s;
          port_gnt_d = NUM_PORTS'(1) << pick_s;
          af_wren_d  = 1'b1;
          af_addr_d  = bus.port_addr[pick_s*AW +: AW];
          af_cmd_d   = wr_sel_s ? 3'b000 : 3'b001;
          rr_d       = (pick_s == PORT_LAST) ? {PORT_BITS{1'b0}} : pick_s + PORT_BITS'(1);
          if (wr_sel_s) begin
            line_d     = bus.port_wr_data[pick_s*LINE_W +: LINE_W];
            wdf_wren_d = 1'b1;
            wdf_data_d = bus.port_wr_data[pick_s*LINE_W +: DW];
            beat_d     = WB_W'(1);
          end else begin
            beat_d     = beat_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (op_wr_q && (BEATS > 1)) begin
          state_d    = S_WR_DATA;
          send_try_s = 1'b1;
        end else begin
          state_d = S_IDLE;
          push_s  = ~op_wr_q;
        end
      end
      S_WR_DATA: begin
        if (beat_q == BEATS_DONE) begin
          state_d = S_IDLE;
        end else begin
          send_try_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Beat output appears the cycle after the edge that sampled wdf_afull low.
    if (send_try_s && !bus.app_wdf_afull) begin
      wdf_wren_d = 1'b1;
      wdf_data_d = line_q[beat_q*DW +: DW];
      beat_d     = beat_q + WB_W'(1);
    end else begin
      wdf_wren_d = wdf_wren_d;
    end
  end

  // Read-beat reassembly and tag FIFO bookkeeping.
  always_comb begin
    rd_beat_d  = rd_beat_q;
    rd_line_d  = rd_line_q;
    rd_valid_d = {NUM_PORTS{1'b0}};
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    pop_s      = 1'b0;
    if (bus.rd_data_valid) begin
      if (tag_cnt_q == {CNT_W{1'b0}}) begin
        err_d = 1'b1;
      end else begin
        rd_line_d[rd_beat_q*DW +: DW] = bus.rd_data_fifo_out;
        if (rd_beat_q == LAST_RBEAT) begin
          rd_data_d  = rd_line_d;
          rd_valid_d = NUM_PORTS'(1) << tag_mem_q[tag_rptr_q];
          pop_s      = 1'b1;
          rd_beat_d  = {RB_W{1'b0}};
        end else begin
          rd_beat_d  = rd_beat_q + RB_W'(1);
        end
      end
    end else begin
      rd_beat_d = rd_beat_q;
    end

    tag_wptr_d = push_s ? ((tag_wptr_q == TAG_LAST) ? {TAG_AW{1'b0}} : tag_wptr_q + TAG_AW'(1))
                        : tag_wptr_q;
    tag_rptr_d = pop_s  ? ((tag_rptr_q == TAG_LAST) ? {TAG_AW{1'b0}} : tag_rptr_q + TAG_AW'(1))
                        : tag_rptr_q;
    case ({push_s, pop_s})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
    tags_full_d = (tag_cnt_d == TAGS_MAX);
  end

  // FSM state, arbitration pointer and MIG command/write-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= {PORT_BITS{1'b0}};
      op_wr_q    <= 1'b0;
      win_q      <= {PORT_BITS{1'b0}};
      line_q     <= {LINE_W{1'b0}};
      beat_q     <= {WB_W{1'b0}};
      port_gnt_q <= {NUM_PORTS{1'b0}};
      af_wren_q  <= 1'b0;
      af_cmd_q   <= 3'b000;
      af_addr_q  <= {AW{1'b0}};
      wdf_wren_q <= 1'b0;
      wdf_data_q <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      op_wr_q    <= op_wr_d;
      win_q      <= win_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      port_gnt_q <= port_gnt_d;
      af_wren_q  <= af_wren_d;
      af_cmd_q   <= af_cmd_d;
      af_addr_q  <= af_addr_d;
      wdf_wren_q <= wdf_wren_d;
      wdf_data_q <= wdf_data_d;
    end
  end

  // Tag FIFO storage and read-return registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_TAGS; i++) begin
        tag_mem_q[i] <= {PORT_BITS{1'b0}};
      end
      tag_wptr_q  <= {TAG_AW{1'b0}};
      tag_rptr_q  <= {TAG_AW{1'b0}};
      tag_cnt_q   <= {CNT_W{1'b0}};
      tags_full_q <= 1'b0;
      rd_beat_q   <= {RB_W{1'b0}};
      rd_line_q   <= {LINE_W{1'b0}};
      rd_valid_q  <= {NUM_PORTS{1'b0}};
      rd_data_q   <= {LINE_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      if (push_s) begin
        tag_mem_q[tag_wptr_q] <= win_q;
      end else begin
        tag_mem_q[tag_wptr_q] <= tag_mem_q[tag_wptr_q];
      end
      tag_wptr_q  <= tag_wptr_d;
      tag_rptr_q  <= tag_rptr_d;
      tag_cnt_q   <= tag_cnt_d;
      tags_full_q <= tags_full_d;
      rd_beat_q   <= rd_beat_d;
      rd_line_q   <= rd_line_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.port_gnt          = port_gnt_q;
  assign bus.port_rd_valid     = rd_valid_q;
  assign bus.port_rd_data      = rd_data_q;
  assign bus.app_af_wren       = af_wren_q;
  assign bus.app_af_cmd        = af_cmd_q;
  assign bus.app_af_addr       = af_addr_q;
  assign bus.app_wdf_wren      = wdf_wren_q;
  assign bus.app_wdf_data      = wdf_data_q;
  assign bus.app_wdf_mask_data = {(DW/8){1'b0}};
  assign bus.rd_tags_full      = tags_full_q;
  assign bus.err_unexp_rd      = err_q;
endmodule

// File: tb/tb_mig_mport_arbiter.sv
module tb_mig_mport_arbiter;
  localparam int NP = 2;
  localparam int DW = 128;
  localparam int NB = 2;
  localparam int AW = 31;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mig_mport_arbiter_if #(.NUM_PORTS(NP), .APPDATA_WIDTH(DW), .BEATS(NB),
                         .INPUT_ADDR_WIDTH(AW)) bus ();

  mig_mport_arbiter #(.NUM_PORTS(NP), .PORT_BITS(1), .APPDATA_WIDTH(DW), .BEATS(NB),
                      .INPUT_ADDR_WIDTH(AW), .RD_TAGS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] ba, bb, bc, bd, ra, rb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ba = {4{32'hAAAA_0000}};
    bb = {4{32'hBBBB_0000}};
    bc = {4{32'hCCCC_0000}};
    bd = {4{32'hDDDD_0000}};
    rst_n                = 1'b0;
    bus.phy_init_done    = 1'b1;
    bus.port_wren        = 2'b01;
    bus.port_rden        = 2'b10;
    bus.port_addr        = {31'h200, 31'h100};
    bus.port_wr_data     = {bd, bc, bb, ba};
    bus.app_af_afull     = 1'b0;
    bus.app_wdf_afull    = 1'b0;
    bus.rd_data_valid    = 1'b0;
    bus.rd_data_fifo_out = {DW{1'b0}};

    // 1. reset with requests held, then no grant while phy_init_done=0
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", bus.port_gnt, 2'b00);
      check("rst_afwren", bus.app_af_wren, 1'b0);
      check("rst_wdfwren", bus.app_wdf_wren, 1'b0);
      check("rst_rdvalid", bus.port_rd_valid, 2'b00);
      check("rst_full", bus.rd_tags_full, 1'b0);
      check("rst_err", bus.err_unexp_rd, 1'b0);
      check("rst_mask", bus.app_wdf_mask_data, 16'h0000);
    end
    rst_n = 1'b1;
    bus.phy_init_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("noinit_gnt", bus.port_gnt, 2'b00);
      check("noinit_afwren", bus.app_af_wren, 1'b0);
    end
    bus.port_wren = 2'b00;
    bus.port_rden = 2'b00;

    // 2. port0 write {B,A} to 0x100
    bus.phy_init_done = 1'b1;
    bus.port_wren = 2'b01;
    tick();
    check("wr0_gnt", bus.port_gnt, 2'b01);
    check("wr0_afwren", bus.app_af_wren, 1'b1);
    check("wr0_cmd", bus.app_af_cmd, 3'b000);
    check("wr0_addr", bus.app_af_addr, 31'h100);
    check("wr0_wdfwren0", bus.app_wdf_wren, 1'b1);
    check("wr0_beat0", bus.app_wdf_data, ba);
    bus.port_wren = 2'b00;
    tick();
    check("wr0_gnt_pulse", bus.port_gnt, 2'b00);
    check("wr0_afwren_pulse", bus.app_af_wren, 1'b0);
    check("wr0_wdfwren1", bus.app_wdf_wren, 1'b1);
    check("wr0_beat1", bus.app_wdf_data, bb);
    tick();
    check("wr0_done", bus.app_wdf_wren, 1'b0);

    // 4. port1 write with wdf backpressure on beat 1 for 3 cycles
    bus.port_wren = 2'b10;
    tick();
    check("wr1_gnt", bus.port_gnt, 2'b10);
    check("wr1_addr", bus.app_af_addr, 31'h200);
    check("wr1_beat0", bus.app_wdf_data, bc);
    bus.port_wren = 2'b00;
    bus.app_wdf_afull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_wdfwren", bus.app_wdf_wren, 1'b0);
    end
    bus.app_wdf_afull = 1'b0;
    tick();
    check("bp_beat1_wren", bus.app_wdf_wren, 1'b1);
    check("bp_beat1_data", bus.app_wdf_data, bd);
    tick();
    check("bp_once", bus.app_wdf_wren, 1'b0);

    // 4b. address FIFO almost full blocks grants
    bus.app_af_afull = 1'b1;
    bus.port_wren = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("afull_gnt", bus.port_gnt, 2'b00);
    end
    bus.app_af_afull = 1'b0;
    tick();
    check("afull_rel_gnt", bus.port_gnt, 2'b10);
    bus.port_wren = 2'b00;
    tick();
    check("afull_rel_beat1", bus.app_wdf_data, bd);
    tick();

    // 3. both ports hold reads: grants alternate 0,1,0,1 every 2 cycles
    bus.port_rden = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_gnt", bus.port_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_cmd", bus.app_af_cmd, 3'b001);
      check("rr_addr", bus.app_af_addr, (i % 2 == 0) ? 31'h100 : 31'h200);
      check("rr_nowdf", bus.app_wdf_wren, 1'b0);
      tick();
      check("rr_gap", bus.port_gnt, 2'b00);
    end

    // 5. four tags outstanding: full, reads blocked, write still granted
    check("full_flag", bus.rd_tags_full, 1'b1);
    tick();
    check("full_blocks_rd", bus.port_gnt, 2'b00);
    bus.port_rden = 2'b00;
    bus.port_wren = 2'b10;
    tick();
    check("full_wr_gnt", bus.port_gnt, 2'b10);
    check("full_wr_cmd", bus.app_af_cmd, 3'b000);
    bus.port_wren = 2'b00;
    tick();
    tick();
    bus.port_rden = 2'b01;
    bus.rd_data_valid = 1'b1;
    bus.rd_data_fifo_out = {4{32'h5000_0001}};
    tick();
    check("ret0_b0_gnt", bus.port_gnt, 2'b00);
    check("ret0_b0_valid", bus.port_rd_valid, 2'b00);
    bus.rd_data_fifo_out = {4{32'h6000_0001}};
    tick();
    check("ret0_valid", bus.port_rd_valid, 2'b01);
    check("ret0_data", bus.port_rd_data, {{4{32'h6000_0001}}, {4{32'h5000_0001}}});
    check("ret0_notfull", bus.rd_tags_full, 1'b0);
    check("ret0_gnt", bus.port_gnt, 2'b00);
    bus.rd_data_valid = 1'b0;
    tick();
    check("rd5_gnt", bus.port_gnt, 2'b01);
    check("rd5_cmd", bus.app_af_cmd, 3'b001);
    bus.port_rden = 2'b00;
    tick();

    // 3b. remaining lines return to ports 1,0,1,0 in issue order
    for (int k = 0; k < 4; k++) begin
      ra = {4{32'h1000_0000 + 32'(k)}};
      rb = {4{32'h2000_0000 + 32'(k)}};
      bus.rd_data_valid = 1'b1;
      bus.rd_data_fifo_out = ra;
      tick();
      check("ret_b0_valid", bus.port_rd_valid, 2'b00);
      bus.rd_data_fifo_out = rb;
      tick();
      check("ret_valid", bus.port_rd_valid, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("ret_data", bus.port_rd_data, {rb, ra});
    end
    bus.rd_data_valid = 1'b0;
    tick();
    check("ret_end_valid", bus.port_rd_valid, 2'b00);
    check("ret_end_full", bus.rd_tags_full, 1'b0);
    check("ret_end_err", bus.err_unexp_rd, 1'b0);

    // 6. unexpected read beat: sticky error, no rd_valid
    bus.rd_data_valid = 1'b1;
    bus.rd_data_fifo_out = {4{32'hDEAD_BEEF}};
    tick();
    check("unexp_err", bus.err_unexp_rd, 1'b1);
    check("unexp_valid", bus.port_rd_valid, 2'b00);
    bus.rd_data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("unexp_sticky", bus.err_unexp_rd, 1'b1);
      check("unexp_novalid", bus.port_rd_valid, 2'b00);
    end
    rst_n = 1'b0;
    tick();
    check("unexp_rst_clear", bus.err_unexp_rd, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_err", bus.err_unexp_rd, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
